// File: rtl/status_reg.sv
// rtl/status_reg.sv - 6502-style processor status register P with interrupt request sequencing.
// Optional decimal flag storage is enabled by defining STATUS_DECIMAL_EN.

package status_reg_pkg;
  typedef logic [7:0] data_t;

  typedef enum logic [3:0] {
    AADD, ASUB, AAND, AOR, AEOR, AASL, ALSR, AROL, AROR, AINC, ADEC, APASS
  } alu_t;

  localparam logic [2:0] FOP_NONE = 3'd0;
  localparam logic [2:0] FOP_CLC  = 3'd1;
  localparam logic [2:0] FOP_SEC  = 3'd2;
  localparam logic [2:0] FOP_CLI  = 3'd3;
  localparam logic [2:0] FOP_SEI  = 3'd4;
  localparam logic [2:0] FOP_CLD  = 3'd5;
  localparam logic [2:0] FOP_SED  = 3'd6;
  localparam logic [2:0] FOP_CLV  = 3'd7;
endpackage

module status_reg
  import status_reg_pkg::*;
#(
  parameter data_t P_RESET  = 8'h24,
  parameter int    NMI_SYNC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_valid,
  input  alu_t       alu_func,
  input  data_t      alu_a,
  input  data_t      alu_b,
  input  data_t      alu_out,
  input  logic       alu_c,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic [2:0] flag_op,
  input  logic       pull_valid,
  input  data_t      pull_data,
  input  logic       push_b,
  output data_t      p_out,
  output data_t      p_push,
  output logic       c_flag,
  input  logic       irq_n,
  input  logic       nmi_n,
  output logic       int_req,
  output logic       int_nmi,
  input  logic       int_ack,
  input  logic       int_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

  logic r_n, r_v, r_i, r_z, r_c;
  logic w_n_nx, w_v_nx, w_i_nx, w_z_nx, w_c_nx;
  logic w_d;
`ifdef STATUS_DECIMAL_EN
  logic r_d, w_d_nx;
`endif

  logic [NMI_SYNC-1:0] r_irq_sync, r_nmi_sync;
  logic                r_nmi_last, r_nmi_pend, w_nmi_pend_nx;
  logic                w_irq_s, w_nmi_fall, w_irq_act, w_ack;
  state_t              r_state, w_state_nx;
  data_t               w_v_add, w_v_sub;
  logic                w_unused;

  assign w_unused = ^pull_data[5:4];

`ifdef STATUS_DECIMAL_EN
  assign w_d = r_d;
`else
  assign w_d = 1'b0;
`endif

  assign w_irq_s    = r_irq_sync[NMI_SYNC-1];
  assign w_nmi_fall = r_nmi_last & ~r_nmi_sync[NMI_SYNC-1];
  assign w_irq_act  = ~w_irq_s & ~r_i;
  assign w_ack      = int_ack && (r_state == ST_REQ);

  assign w_v_add = ~(alu_a ^ alu_b) & (alu_a ^ alu_out);
  assign w_v_sub =  (alu_a ^ alu_b) & (alu_a ^ alu_out);

  // Write priority: pull, then explicit flag op, then ALU; ack then forces I regardless.
  always_comb begin
    w_n_nx = r_n;
    w_v_nx = r_v;
    w_i_nx = r_i;
    w_z_nx = r_z;
    w_c_nx = r_c;
`ifdef STATUS_DECIMAL_EN
    w_d_nx = r_d;
`endif
    if (pull_valid) begin
      w_n_nx = pull_data[7];
      w_v_nx = pull_data[6];
      w_i_nx = pull_data[2];
      w_z_nx = pull_data[1];
      w_c_nx = pull_data[0];
`ifdef STATUS_DECIMAL_EN
      w_d_nx = pull_data[3];
`endif
    end else if (flag_op != FOP_NONE) begin
      case (flag_op)
        FOP_CLC: w_c_nx = 1'b0;
        FOP_SEC: w_c_nx = 1'b1;
        FOP_CLI: w_i_nx = 1'b0;
        FOP_SEI: w_i_nx = 1'b1;
`ifdef STATUS_DECIMAL_EN
        FOP_CLD: w_d_nx = 1'b0;
        FOP_SED: w_d_nx = 1'b1;
`endif
        FOP_CLV: w_v_nx = 1'b0;
        default: ;
      endcase
    end else if (alu_valid) begin
      if (upd_nz) begin
        w_n_nx = alu_out[7];
        w_z_nx = (alu_out == '0);
      end
      if (upd_c) w_c_nx = alu_c;
      if (upd_v) begin
        if (alu_func == AADD)      w_v_nx = w_v_add[7];
        else if (alu_func == ASUB) w_v_nx = w_v_sub[7];
      end
    end
    if (w_ack) w_i_nx = 1'b1;
  end

  // A fresh NMI edge in the clearing cycle keeps the pending bit set.
  always_comb begin
    w_nmi_pend_nx = r_nmi_pend;
    if (w_nmi_fall)  w_nmi_pend_nx = 1'b1;
    else if (w_ack)  w_nmi_pend_nx = 1'b0;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:    if (r_nmi_pend || w_irq_act) w_state_nx = ST_REQ;
      ST_REQ:     if (int_ack) w_state_nx = ST_SERVICE;
                  else if (!r_nmi_pend && !w_irq_act) w_state_nx = ST_IDLE;
      ST_SERVICE: if (int_done) w_state_nx = ST_IDLE;
      default:    w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n        <= P_RESET[7];
      r_v        <= P_RESET[6];
      r_i        <= P_RESET[2];
      r_z        <= P_RESET[1];
      r_c        <= P_RESET[0];
      r_irq_sync <= '1;
      r_nmi_sync <= '1;
      r_nmi_last <= 1'b1;
      r_nmi_pend <= 1'b0;
      r_state    <= ST_IDLE;
    end else begin
      r_n        <= w_n_nx;
      r_v        <= w_v_nx;
      r_i        <= w_i_nx;
      r_z        <= w_z_nx;
      r_c        <= w_c_nx;
      r_irq_sync <= {r_irq_sync[NMI_SYNC-2:0], irq_n};
      r_nmi_sync <= {r_nmi_sync[NMI_SYNC-2:0], nmi_n};
      r_nmi_last <= r_nmi_sync[NMI_SYNC-1];
      r_nmi_pend <= w_nmi_pend_nx;
      r_state    <= w_state_nx;
    end
  end

`ifdef STATUS_DECIMAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_d <= P_RESET[3];
    else        r_d <= w_d_nx;
  end
`endif

  assign p_out   = {r_n, r_v, 1'b1, 1'b0, w_d, r_i, r_z, r_c};
  assign p_push  = {p_out[7:5], push_b, p_out[3:0]};
  assign c_flag  = r_c;
  assign int_req = (r_state == ST_REQ);
  assign int_nmi = r_nmi_pend;

endmodule
